// File: rtl/gon_pkg.sv
// gon_pkg: shared GON bus widths and the transmitter state encoding
package gon_pkg;
  localparam int GON_DATA_WIDTH = 64;
  localparam int GON_TAG_WIDTH  = 4;
  typedef enum logic [1:0] {IDLE, SEND, DONE} gon_tx_state_t;
endpackage

// File: rtl/gon_tx_ctrl_if.sv
// gon_tx_ctrl_if: upstream push channel plus the multicast bus driven towards the MCC array
//   in_data/in_valid/in_ready : GLB-side push handshake
//   data_out/tag_out/enable_out/ready_in : GON bus handshake
//   master = transmitter, slave = upstream source and MCC array
interface gon_tx_ctrl_if #(parameter int DW = gon_pkg::GON_DATA_WIDTH, parameter int TW = gon_pkg::GON_TAG_WIDTH);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic          enable_out;
  modport master (input in_data, in_valid, ready_in, output in_ready, data_out, tag_out, enable_out);
  modport slave (output in_data, in_valid, ready_in, input in_ready, data_out, tag_out, enable_out);
endinterface

// File: rtl/gon_tx_fifo.sv
// gon_tx_fifo: synchronous FIFO buffering upstream words ahead of the bus
//   clk, reset (async active-low), push_i/data_i write side, pop_i read side,
//   full_o/empty_o status, head_o oldest entry
module gon_tx_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          wr_en, rd_en;
  // Extra pointer bit tells full from empty when the index bits coincide.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/gon_tx_ctrl.sv
// gon_tx_ctrl: GON multicast bus transmitter stamping buffered words with a programmed tag sequence
//   clk, reset (async active-low)
//   start + cfg_tag_start/cfg_tag_end/cfg_words : sequence programming, sampled in IDLE
//   bus (master) : upstream push channel and tagged bus output
//   busy : sequence active, done : one-cycle pulse after the final transfer
module gon_tx_ctrl
  import gon_pkg::*;
#(
  parameter int DATA_WIDTH = GON_DATA_WIDTH,
  parameter int TAG_WIDTH  = GON_TAG_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TAG_WIDTH-1:0] cfg_tag_start,
  input  logic [TAG_WIDTH-1:0] cfg_tag_end,
  input  logic [CNT_WIDTH-1:0] cfg_words,
  gon_tx_ctrl_if.master        bus,
  output logic                 busy,
  output logic                 done
);
  gon_tx_state_t        state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, end_q, end_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, words_q, words_d;
  logic                 full, empty, enable, xfer, last_word;
  logic [DATA_WIDTH-1:0] head;
  gon_tx_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.in_valid),
    .data_i  (bus.in_data),
    .pop_i   (xfer),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );
  // enable depends only on registered state, so the bus never sees a ready_in loop.
  assign enable         = (state_q == SEND) && !empty;
  assign xfer           = enable && bus.ready_in;
  assign last_word      = CNT_WIDTH'(cnt_q + 1'b1) == words_q;
  assign bus.in_ready   = !full;
  assign bus.enable_out = enable;
  assign bus.data_out   = enable ? head : '0;
  assign bus.tag_out    = tag_q;
  assign busy           = state_q != IDLE;
  assign done           = state_q == DONE;
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    words_d = words_q;
    case (state_q)
      IDLE: if (start) begin
        tag_d   = cfg_tag_start;
        end_d   = cfg_tag_end;
        words_d = cfg_words;
        cnt_d   = '0;
        state_d = cfg_words == '0 ? DONE : SEND;
      end
      SEND: if (xfer) begin
        cnt_d   = last_word ? '0 : cnt_q + 1'b1;
        state_d = last_word && tag_q == end_q ? DONE : SEND;
        tag_d   = last_word && tag_q != end_q ? tag_q + 1'b1 : tag_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tag_q   <= '1;
      cnt_q   <= '0;
      end_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      words_q <= words_d;
    end
  end
endmodule

// File: tb/tb_gon_tx_ctrl.sv
// tb_gon_tx_ctrl: directed and random stimulus against a tag-list/queue reference model
module tb_gon_tx_ctrl;
  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [3:0]  cfg_tag_start = 0, cfg_tag_end = 0;
  logic [7:0]  cfg_words = 0;
  logic        busy, done;
  int          total = 0, bad = 0;
  logic [63:0] mq[$];
  logic [3:0]  mt[$];
  logic [3:0]  m_tag;
  int          phase;
  gon_tx_ctrl_if #(.DW(64), .TW(4)) bus ();
  gon_tx_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_tag_start(cfg_tag_start),
    .cfg_tag_end(cfg_tag_end), .cfg_words(cfg_words), .bus(bus.master),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    mq.delete();
    mt.delete();
    m_tag = 4'hF;
    phase = 0;
  endtask
  task automatic cyc(input logic st, input logic [3:0] ts, input logic [3:0] te, input logic [7:0] w,
                     input logic v, input logic [63:0] d, input logic rdy);
    logic en, full;
    logic [3:0] t;
    full = mq.size() == 4;
    en = phase == 1 && mq.size() > 0;
    check("in_ready", bus.in_ready, !full);
    check("enable_out", bus.enable_out, en);
    check("data_out", bus.data_out, en ? mq[0] : 64'h0);
    check("tag_out", bus.tag_out, m_tag);
    check("busy", busy, phase != 0);
    check("done", done, phase == 2);
    start = st; cfg_tag_start = ts; cfg_tag_end = te; cfg_words = w;
    bus.in_valid = v; bus.in_data = d; bus.ready_in = rdy;
    @(posedge clk);
    if (!reset) mreset();
    else begin
      if (phase == 2) phase = 0;
      else if (phase == 1) begin
        if (en && rdy) begin
          void'(mq.pop_front());
          void'(mt.pop_front());
          if (mt.size() == 0) phase = 2;
          else m_tag = mt[0];
        end
      end else if (st) begin
        t = ts;
        if (w != 0) forever begin
          for (int i = 0; i < int'(w); i++) mt.push_back(t);
          if (t == te) break;
          t = t + 4'd1;
        end
        m_tag = ts;
        phase = mt.size() == 0 ? 2 : 1;
      end
      if (v && !full) mq.push_back(d);
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, rdy);
  endtask
  task automatic push(input logic [63:0] d);
    cyc(0, 0, 0, 0, 1, d, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && phase != 0; i++) cyc(0, 0, 0, 0, 1, {$urandom, $urandom}, 1);
    check("drain_timeout", phase, 0);
    while (mq.size() > 0 && total < 100000) begin
      cyc(1, 4'd0, 4'd0, 8'd1, 0, 0, 1);
      idle(1, 1);
      while (phase != 0) cyc(0, 0, 0, 0, 0, 0, 1);
    end
  endtask
  initial begin
    mreset();
    bus.in_valid = 0; bus.in_data = 0; bus.ready_in = 0;
    @(negedge clk);
    idle(2, 0);
    reset = 1;
    idle(1, 0);
    // T2 basic
    for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
    cyc(1, 4'd1, 4'd2, 8'd2, 0, 0, 1);
    idle(6, 1);
    // T3 backpressure on the second word
    for (int i = 0; i < 4; i++) push(64'hB0 + 64'(i));
    cyc(1, 4'd1, 4'd2, 8'd2, 0, 0, 1);
    idle(1, 1);
    idle(3, 0);
    idle(5, 1);
    // T4 wrap
    for (int i = 0; i < 4; i++) push(64'hC0 + 64'(i));
    cyc(1, 4'd14, 4'd1, 8'd1, 0, 0, 1);
    idle(6, 1);
    // T5 full FIFO, then pop+push while full
    cyc(1, 4'd3, 4'd3, 8'd6, 1, 64'hD0, 0);
    for (int i = 1; i < 5; i++) push(64'hD0 + 64'(i));
    push(64'hD4);
    cyc(0, 0, 0, 0, 1, 64'hD4, 1);
    cyc(0, 0, 0, 0, 1, 64'hD4, 1);
    drain();
    // T6 zero words, then start during SEND
    cyc(1, 4'd5, 4'd6, 8'd0, 0, 0, 1);
    idle(3, 1);
    for (int i = 0; i < 3; i++) push(64'hE0 + 64'(i));
    cyc(1, 4'd2, 4'd3, 8'd2, 0, 0, 1);
    cyc(1, 4'd9, 4'd9, 8'd1, 0, 0, 1);
    cyc(1, 4'd9, 4'd9, 8'd1, 1, 64'hE3, 0);
    cyc(0, 0, 0, 0, 1, 64'hE4, 1);
    idle(6, 1);
    drain();
    // T1 reset mid-SEND with three words buffered
    for (int i = 0; i < 3; i++) push(64'hF0 + 64'(i));
    cyc(1, 4'd1, 4'd3, 8'd4, 0, 0, 0);
    reset = 0;
    mreset();
    #1;
    check("rst_enable", bus.enable_out, 0);
    check("rst_tag", bus.tag_out, 4'hF);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    @(negedge clk);
    idle(2, 1);
    reset = 1;
    idle(2, 1);
    cyc(1, 4'd1, 4'd1, 8'd1, 0, 0, 1);
    idle(3, 1);
    for (int i = 0; i < 3; i++) push(64'h51 + 64'(i));
    drain();
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) == 0, 4'($urandom), 4'($urandom), 8'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
